tlb_ram_ctrl: RTL and testbench

//   Initiator/controller for the 8-entry, 48-bit dual-read/single-write TLB RAM unit. Drives the
//   RAM's write port for inserts and purges, and both read ports to scan two entries per cycle
//   for a tag match. Sits between the translation pipeline (lookup/insert requests) and the RAM.

---
 rtl/tlb_ram_ctrl_if.sv | 39 +++
 rtl/tlb_ram_ctrl.sv | 130 +++++++++++++
 tb/tb_tlb_ram_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_ram_ctrl_if.sv
// Bundle of the lookup/insert/purge handshakes and the TLB RAM port signals.
// The controller uses the slave modport; the pipeline/RAM side uses master.
interface tlb_ram_ctrl_if #(
    parameter int ADR_W  = 3,
    parameter int DATA_W = 48,
    parameter int TAG_W  = 20
);
    logic              lkValid;
    logic              lkReady;
    logic [TAG_W-1:0]  lkTag;
    logic              rspValid;
    logic              rspHit;
    logic [ADR_W-1:0]  rspIdx;
    logic [DATA_W-1:0] rspData;
    logic              insValid;
    logic              insReady;
    logic [DATA_W-1:0] insData;
    logic              purgeReq;
    logic              purgeBusy;
    logic [ADR_W-1:0]  ramReadAdrA;
    logic [ADR_W-1:0]  ramReadAdrB;
    logic [DATA_W-1:0] ramDataOutA;
    logic [DATA_W-1:0] ramDataOutB;
    logic              ramWEnable;
    logic [ADR_W-1:0]  ramWriteAdr;
    logic [DATA_W-1:0] ramDataIn;

    modport slave (
        input  lkValid, lkTag, insValid, insData, purgeReq, ramDataOutA, ramDataOutB,
        output lkReady, rspValid, rspHit, rspIdx, rspData, insReady, purgeBusy,
               ramReadAdrA, ramReadAdrB, ramWEnable, ramWriteAdr, ramDataIn
    );

    modport master (
        output lkValid, lkTag, insValid, insData, purgeReq, ramDataOutA, ramDataOutB,
        input  lkReady, rspValid, rspHit, rspIdx, rspData, insReady, purgeBusy,
               ramReadAdrA, ramReadAdrB, ramWEnable, ramWriteAdr, ramDataIn
    );
endinterface

// File: rtl/tlb_ram_ctrl.sv
// TLB RAM controller: serialises inserts (round-robin victim), purges and
// two-entries-per-cycle tag scans onto a dual-read/single-write RAM.
// Entry layout (MSB first): valid, 3 rights bits, TAG_W tag, physical page.
module tlb_ram_ctrl #(
    parameter int ENTRIES = 8,
    parameter int ADR_W   = 3,
    parameter int DATA_W  = 48,
    parameter int TAG_W   = 20
) (
    input logic          clk,
    input logic          rst,
    tlb_ram_ctrl_if.slave bus
);
    localparam int TAG_LSB = DATA_W - 4 - TAG_W;

    typedef enum logic [1:0] {IDLE, SCAN, FILL, PURGE} state_t;

    state_t            state;
    logic [TAG_W-1:0]  tagReg;
    logic [ADR_W-1:0]  victim;
    logic [ADR_W-1:0]  adrA;
    logic [ADR_W-1:0]  adrB;
    logic [ADR_W-1:0]  wAdr;
    logic [DATA_W-1:0] wData;
    logic              wEn;
    logic              busy;
    logic              rspValidReg;
    logic              rspHitReg;
    logic [ADR_W-1:0]  rspIdxReg;
    logic [DATA_W-1:0] rspDataReg;
    logic              hitA;
    logic              hitB;
    logic              lastPair;
    logic              insRdy;

    // Tag compare on both read ports and end-of-table detection.
    always_comb begin
        hitA     = bus.ramDataOutA[DATA_W-1] && (bus.ramDataOutA[TAG_LSB +: TAG_W] == tagReg);
        hitB     = bus.ramDataOutB[DATA_W-1] && (bus.ramDataOutB[TAG_LSB +: TAG_W] == tagReg);
        lastPair = (adrB == ADR_W'(ENTRIES - 1));
        insRdy   = (state == IDLE) && !rst && !bus.purgeReq;
    end

    assign bus.insReady    = insRdy;
    assign bus.lkReady     = insRdy && !bus.insValid;
    // Write enable and response strobe are masked by reset so an aborted
    // operation cannot complete in the reset cycle.
    assign bus.ramWEnable  = wEn && !rst;
    assign bus.rspValid    = rspValidReg && !rst;
    assign bus.ramWriteAdr = wAdr;
    assign bus.ramDataIn   = wData;
    assign bus.ramReadAdrA = adrA;
    assign bus.ramReadAdrB = adrB;
    assign bus.rspHit      = rspHitReg;
    assign bus.rspIdx      = rspIdxReg;
    assign bus.rspData     = rspDataReg;
    assign bus.purgeBusy   = busy;

    // Control FSM with registered RAM-side and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tagReg      <= '0;
            victim      <= '0;
            adrA        <= '0;
            adrB        <= '0;
            wAdr        <= '0;
            wData       <= '0;
            wEn         <= 1'b0;
            busy        <= 1'b0;
            rspValidReg <= 1'b0;
            rspHitReg   <= 1'b0;
            rspIdxReg   <= '0;
            rspDataReg  <= '0;
        end else begin
            rspValidReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.purgeReq) begin
                        state <= PURGE;
                        busy  <= 1'b1;
                        wEn   <= 1'b1;
                        wAdr  <= '0;
                        wData <= '0;
                    end else if (bus.insValid) begin
                        state <= FILL;
                        wEn   <= 1'b1;
                        wAdr  <= victim;
                        wData <= bus.insData;
                    end else if (bus.lkValid) begin
                        state  <= SCAN;
                        tagReg <= bus.lkTag;
                        adrA   <= '0;
                        adrB   <= ADR_W'(1);
                    end
                end
                SCAN: begin
                    if (hitA || hitB || lastPair) begin
                        state       <= IDLE;
                        rspValidReg <= 1'b1;
                        rspHitReg   <= hitA || hitB;
                        rspIdxReg   <= hitA ? adrA : (hitB ? adrB : '0);
                        rspDataReg  <= hitA ? bus.ramDataOutA : (hitB ? bus.ramDataOutB : '0);
                        adrA        <= '0;
                        adrB        <= '0;
                    end else begin
                        adrA <= adrA + ADR_W'(2);
                        adrB <= adrB + ADR_W'(2);
                    end
                end
                FILL: begin
                    state  <= IDLE;
                    wEn    <= 1'b0;
                    victim <= victim + ADR_W'(1);
                end
                PURGE: begin
                    if (wAdr == ADR_W'(ENTRIES - 1)) begin
                        state  <= IDLE;
                        wEn    <= 1'b0;
                        busy   <= 1'b0;
                        wAdr   <= '0;
                        victim <= '0;
                    end else begin
                        wAdr <= wAdr + ADR_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_ram_ctrl.sv
// Scoreboard bench for tlb_ram_ctrl with a behavioural 8x48 RAM attached.
module tb_tlb_ram_ctrl;
    typedef struct {
        logic        hit;
        logic [2:0]  idx;
        logic [47:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [2:0]  adr;
        logic [47:0] data;
        int          cyc;
        logic        busy;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;
    logic [2:0]  victimM = '0;
    logic [47:0] mem [8];
    rsp_t rspQ[$];
    wr_t  wrQ[$];
    rsp_t eR;
    wr_t  eW;

    tlb_ram_ctrl_if bus ();

    tlb_ram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.ramDataOutA = mem[bus.ramReadAdrA];
    assign bus.ramDataOutB = mem[bus.ramReadAdrB];
    always @(posedge clk) if (bus.ramWEnable) mem[bus.ramWriteAdr] <= bus.ramDataIn;

    task automatic check(input string name, input longint act, input longint exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [47:0] ent(input logic [19:0] tag, input logic [23:0] ppn);
        return {1'b1, 3'b000, tag, ppn};
    endfunction

    // Response and write monitors
    always @(negedge clk) begin
        if (bus.rspValid) begin
            if (rspQ.size() == 0) check("rsp_spurious", 1, 0);
            else begin
                eR = rspQ.pop_front();
                check("rsp_hit", bus.rspHit, eR.hit);
                check("rsp_idx", bus.rspIdx, eR.idx);
                check("rsp_data", bus.rspData, eR.data);
                check("rsp_cycle", cyc, eR.cyc);
            end
        end
        if (bus.ramWEnable) begin
            if (wrQ.size() == 0) check("wr_spurious", 1, 0);
            else begin
                eW = wrQ.pop_front();
                check("wr_adr", bus.ramWriteAdr, eW.adr);
                check("wr_data", bus.ramDataIn, eW.data);
                check("wr_cycle", cyc, eW.cyc);
                check("wr_busy", bus.purgeBusy, eW.busy);
            end
        end
    end

    task automatic waitAccept(input bit isIns, output int acc);
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (isIns ? bus.insReady : bus.lkReady) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check(isIns ? "ins_accept_timeout" : "lk_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rspQ.size() == 0 && wrQ.size() == 0) break;
        end
        if (rspQ.size() != 0 || wrQ.size() != 0) begin
            check("drain_timeout", 0, 1);
            rspQ.delete();
            wrQ.delete();
        end
    endtask

    task automatic doLookup(input logic [19:0] tag, input logic hit, input logic [2:0] idx,
                            input logic [47:0] data, input int lat);
        int acc;
        @(posedge clk); #1;
        bus.lkValid = 1'b1;
        bus.lkTag   = tag;
        waitAccept(1'b0, acc);
        rspQ.push_back(rsp_t'{hit, idx, data, acc + lat});
        @(posedge clk); #1;
        bus.lkValid = 1'b0;
        drain();
    endtask

    task automatic doInsert(input logic [47:0] data);
        int acc;
        @(posedge clk); #1;
        bus.insValid = 1'b1;
        bus.insData  = data;
        waitAccept(1'b1, acc);
        wrQ.push_back(wr_t'{victimM, data, acc + 1, 1'b0});
        victimM = victimM + 3'd1;
        @(posedge clk); #1;
        bus.insValid = 1'b0;
        drain();
    endtask

    task automatic doPurge();
        int acc;
        @(posedge clk); #1;
        bus.purgeReq = 1'b1;
        @(negedge clk);
        acc = cyc;
        for (int i = 0; i < 8; i++) wrQ.push_back(wr_t'{3'(i), 48'h0, acc + 1 + i, 1'b1});
        @(posedge clk); #1;
        bus.purgeReq = 1'b0;
        drain();
        @(negedge clk);
        check("purge_busy_low", bus.purgeBusy, 0);
        victimM = '0;
    endtask

    initial begin
        int accI;
        int accL;
        logic [47:0] e5;
        rst          = 1'b1;
        bus.lkValid  = 1'b0;
        bus.lkTag    = '0;
        bus.insValid = 1'b0;
        bus.insData  = '0;
        bus.purgeReq = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_lkReady", bus.lkReady, 0);
        check("rst_insReady", bus.insReady, 0);
        check("rst_rspValid", bus.rspValid, 0);
        check("rst_wen", bus.ramWEnable, 0);
        check("rst_busy", bus.purgeBusy, 0);
        check("rst_adrA", bus.ramReadAdrA, 0);
        check("rst_adrB", bus.ramReadAdrB, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_lkReady", bus.lkReady, 1);

        // 1: purge then miss
        doPurge();
        doLookup(20'h00012, 1'b0, 3'd0, 48'h0, 5);

        // 2: single insert and hit at idx 0
        doInsert(48'h800120120034);
        doLookup(20'h00120, 1'b1, 3'd0, 48'h800120120034, 2);

        // 3: nine inserts wrap the victim pointer
        doPurge();
        for (int i = 1; i <= 9; i++) doInsert(ent(20'(i), 24'h300000 + 24'(i)));
        doLookup(20'h00001, 1'b0, 3'd0, 48'h0, 5);
        doLookup(20'h00009, 1'b1, 3'd0, ent(20'h9, 24'h300009), 2);
        doLookup(20'h00008, 1'b1, 3'd7, ent(20'h8, 24'h300008), 5);

        // 4: duplicate tag, lower index wins
        doPurge();
        doInsert(ent(20'h100, 24'h000100));
        doInsert(ent(20'h101, 24'h000101));
        doInsert(ent(20'h055, 24'h0000A2));
        doInsert(ent(20'h055, 24'h0000B3));
        doLookup(20'h00055, 1'b1, 3'd2, ent(20'h055, 24'h0000A2), 3);

        // 5: simultaneous insert and lookup
        e5 = ent(20'h777, 24'h777777);
        @(posedge clk); #1;
        bus.insValid = 1'b1;
        bus.insData  = e5;
        bus.lkValid  = 1'b1;
        bus.lkTag    = 20'h777;
        @(negedge clk);
        check("both_lkReady", bus.lkReady, 0);
        check("both_insReady", bus.insReady, 1);
        accI = cyc;
        wrQ.push_back(wr_t'{3'd4, e5, accI + 1, 1'b0});
        victimM = 3'd5;
        @(posedge clk); #1;
        bus.insValid = 1'b0;
        waitAccept(1'b0, accL);
        check("lk_after_ins_cycle", accL, accI + 2);
        rspQ.push_back(rsp_t'{1'b1, 3'd4, e5, accL + 4});
        @(posedge clk); #1;
        bus.lkValid = 1'b0;
        drain();

        // 6a: reset during scan pair 1
        @(posedge clk); #1;
        bus.lkValid = 1'b1;
        bus.lkTag   = 20'hFFFFF;
        waitAccept(1'b0, accL);
        @(posedge clk); #1;
        bus.lkValid = 1'b0;
        @(posedge clk); #1;
        check("scan_p1_adrA", bus.ramReadAdrA, 2);
        check("scan_p1_adrB", bus.ramReadAdrB, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        victimM = '0;
        @(negedge clk);
        check("scanrst_lkReady", bus.lkReady, 1);
        check("scanrst_adrA", bus.ramReadAdrA, 0);
        repeat (8) @(negedge clk);
        doInsert(ent(20'h0AA, 24'h0000AA));

        // 6b: reset during purge index 3
        @(posedge clk); #1;
        bus.purgeReq = 1'b1;
        @(negedge clk);
        accI = cyc;
        for (int i = 0; i < 3; i++) wrQ.push_back(wr_t'{3'(i), 48'h0, accI + 1 + i, 1'b1});
        @(posedge clk); #1;
        bus.purgeReq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("purge_idx3_adr", bus.ramWriteAdr, 3);
        rst = 1'b1;
        #1;
        check("purgerst_wen", bus.ramWEnable, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        victimM = '0;
        @(negedge clk);
        check("purgerst_busy", bus.purgeBusy, 0);
        check("purgerst_lkReady", bus.lkReady, 1);
        drain();
        doLookup(20'h00055, 1'b1, 3'd3, ent(20'h055, 24'h0000B3), 3);
        doLookup(20'h00777, 1'b1, 3'd4, e5, 4);
        doLookup(20'h000AA, 1'b0, 3'd0, 48'h0, 5);
        doInsert(ent(20'h0BB, 24'h0000BB));
        doLookup(20'h000BB, 1'b1, 3'd0, ent(20'h0BB, 24'h0000BB), 2);

        repeat (5) @(negedge clk);
        check("rspQ_empty", rspQ.size(), 0);
        check("wrQ_empty", wrQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
